// File: rtl/alu_32bit_if.sv
// rtl/alu_32bit_if.sv - operand/control/result bundle between the EX stage and the ALU
interface alu_32bit_if;
   logic [3:0]  ALUControl;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] ALUResult;
   logic        Zero;

   modport master (output ALUControl, output A, output B, input ALUResult, input Zero);
   modport slave  (input ALUControl, input A, input B, output ALUResult, output Zero);
endinterface

// File: rtl/alu_32bit.sv
// rtl/alu_32bit.sv - combinational 32-bit MIPS-style ALU with clocked HI/LO product registers
module alu_32bit (
   input  logic        Clk,
   input  logic        Reset,
   alu_32bit_if.slave  bus
);

   typedef enum logic [3:0] {
      OP_AND  = 4'd0,
      OP_OR   = 4'd1,
      OP_ADD  = 4'd2,
      OP_XOR  = 4'd3,
      OP_NOR  = 4'd4,
      OP_SLL  = 4'd5,
      OP_SUB  = 4'd6,
      OP_LTZ  = 4'd7,
      OP_SLT  = 4'd8,
      OP_LEZ  = 4'd9,
      OP_SRL  = 4'd10,
      OP_SRA  = 4'd11,
      OP_SLTU = 4'd12,
      OP_MULT = 4'd13,
      OP_MFHI = 4'd14,
      OP_MFLO = 4'd15
   } alu_op_e;

   logic [31:0] hi;
   logic [31:0] lo;
   logic [63:0] product;
   logic [4:0]  shamt;
   alu_op_e     op;
   logic [31:0] result;

   assign op    = alu_op_e'(bus.ALUControl);
   assign shamt = bus.A[4:0];
   // Sign-extended 64x64 multiply; its low 64 bits equal the signed 32x32 product.
   assign product = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};

   always_comb begin
      result = 32'h0;
      case (op)
         OP_AND:  result = bus.A & bus.B;
         OP_OR:   result = bus.A | bus.B;
         OP_ADD:  result = bus.A + bus.B;
         OP_XOR:  result = bus.A ^ bus.B;
         OP_NOR:  result = ~(bus.A | bus.B);
         OP_SLL:  result = bus.B << shamt;
         OP_SUB:  result = bus.A - bus.B;
         OP_LTZ:  result = {31'h0, bus.A[31]};
         OP_SLT:  result = {31'h0, ($signed(bus.A) < $signed(bus.B))};
         OP_LEZ:  result = {31'h0, (bus.A[31] | (bus.A == 32'h0))};
         OP_SRL:  result = bus.B >> shamt;
         OP_SRA:  result = $unsigned($signed(bus.B) >>> shamt);
         OP_SLTU: result = {31'h0, (bus.A < bus.B)};
         OP_MULT: result = product[31:0];
         OP_MFHI: result = hi;
         OP_MFLO: result = lo;
         default: result = 32'h0;
      endcase
   end

   assign bus.ALUResult = result;
   assign bus.Zero      = (result == 32'h0);

   // Move-from ops read the registered value, so a MULT is visible only after its edge.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         hi <= 32'h0;
         lo <= 32'h0;
      end else if (op == OP_MULT) begin
         hi <= product[63:32];
         lo <= product[31:0];
      end
   end

endmodule

// File: tb/tb_alu_32bit.sv
// tb/tb_alu_32bit.sv - directed self-checking bench for alu_32bit
module tb_alu_32bit;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   alu_32bit_if bus ();

   alu_32bit dut (
      .Clk   (clk),
      .Reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      bus.ALUControl = 4'd14;
      bus.A = 32'h0;
      bus.B = 32'h0;
      #1;
      checks++;
      if (bus.ALUResult !== 32'h0 || bus.Zero !== 1'b1) begin
         errors++;
         $display("FAIL reset_mfhi: got %h zero=%b, want 00000000 zero=1", bus.ALUResult, bus.Zero);
      end
      bus.ALUControl = 4'd15;
      #1;
      checks++;
      if (bus.ALUResult !== 32'h0) begin
         errors++;
         $display("FAIL reset_mflo: got %h, want 00000000", bus.ALUResult);
      end
   endtask

   task automatic test_branch_flags();
      logic [3:0]  op   [6] = '{4'd7, 4'd7, 4'd7, 4'd9, 4'd9, 4'd9};
      logic [31:0] a    [6] = '{32'hFFFFFFFB, 32'h0, 32'h3, 32'hFFFFFFFB, 32'h0, 32'h3};
      logic [31:0] res  [6] = '{32'h1, 32'h0, 32'h0, 32'h1, 32'h1, 32'h0};
      logic        zero [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
         bus.ALUControl = op[i];
         bus.A = a[i];
         bus.B = 32'h0;
         #1;
         checks++;
         if (bus.ALUResult !== res[i] || bus.Zero !== zero[i]) begin
            errors++;
            $display("FAIL flag_%0d op=%0d a=%h: got %h zero=%b, want %h zero=%b",
                     i, op[i], a[i], bus.ALUResult, bus.Zero, res[i], zero[i]);
         end
      end
      // B must be ignored by LTZ/LEZ
      bus.ALUControl = 4'd9;
      bus.A = 32'h0;
      bus.B = 32'hFFFFFFFF;
      #1;
      checks++;
      if (bus.ALUResult !== 32'h1) begin
         errors++;
         $display("FAIL lez_ignores_b: got %h, want 00000001", bus.ALUResult);
      end
   endtask

   task automatic test_arith_logic();
      logic [3:0]  op  [9] = '{4'd2, 4'd6, 4'd4, 4'd8, 4'd8, 4'd12, 4'd0, 4'd1, 4'd3};
      logic [31:0] a   [9] = '{32'h7FFFFFFF, 32'h5, 32'h0, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF,
                               32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0};
      logic [31:0] b   [9] = '{32'h1, 32'h5, 32'h0, 32'h1, 32'hFFFFFFFF, 32'h1,
                               32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0};
      logic [31:0] res [9] = '{32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0,
                               32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00};
      for (int i = 0; i < 9; i++) begin
         bus.ALUControl = op[i];
         bus.A = a[i];
         bus.B = b[i];
         #1;
         checks++;
         if (bus.ALUResult !== res[i] || bus.Zero !== (res[i] == 32'h0)) begin
            errors++;
            $display("FAIL arith_%0d op=%0d: got %h zero=%b, want %h zero=%b",
                     i, op[i], bus.ALUResult, bus.Zero, res[i], (res[i] == 32'h0));
         end
      end
   endtask

   task automatic test_shifts();
      logic [3:0]  op  [6] = '{4'd5, 4'd10, 4'd11, 4'd5, 4'd11, 4'd10};
      logic [31:0] a   [6] = '{32'h4, 32'h4, 32'h4, 32'h0, 32'h24, 32'h1F};
      logic [31:0] res [6] = '{32'h00000010, 32'h08000000, 32'hF8000000,
                               32'h80000001, 32'hF8000000, 32'h00000001};
      for (int i = 0; i < 6; i++) begin
         bus.ALUControl = op[i];
         bus.A = a[i];
         bus.B = 32'h80000001;
         #1;
         checks++;
         if (bus.ALUResult !== res[i]) begin
            errors++;
            $display("FAIL shift_%0d op=%0d a=%h: got %h, want %h", i, op[i], a[i], bus.ALUResult, res[i]);
         end
      end
   endtask

   task automatic test_mult();
      // First product 2^32 leaves HI=1, LO=0 so the old-value check below is distinctive.
      @(negedge clk);
      bus.ALUControl = 4'd13;
      bus.A = 32'h00010000;
      bus.B = 32'h00010000;
      @(posedge clk);
      #1;
      bus.ALUControl = 4'd14;
      #1;
      checks++;
      if (bus.ALUResult !== 32'h1) begin
         errors++;
         $display("FAIL mult1_hi: got %h, want 00000001", bus.ALUResult);
      end
      @(negedge clk);
      bus.ALUControl = 4'd13;
      bus.A = 32'hFFFFFFFE;
      bus.B = 32'h3;
      #1;
      checks++;
      if (bus.ALUResult !== 32'hFFFFFFFA || bus.Zero !== 1'b0) begin
         errors++;
         $display("FAIL mult_comb: got %h zero=%b, want fffffffa zero=0", bus.ALUResult, bus.Zero);
      end
      bus.ALUControl = 4'd14;
      #1;
      checks++;
      if (bus.ALUResult !== 32'h1) begin
         errors++;
         $display("FAIL mfhi_old: got %h, want 00000001", bus.ALUResult);
      end
      bus.ALUControl = 4'd13;
      @(posedge clk);
      #1;
      bus.ALUControl = 4'd14;
      #1;
      checks++;
      if (bus.ALUResult !== 32'hFFFFFFFF) begin
         errors++;
         $display("FAIL mfhi_new: got %h, want ffffffff", bus.ALUResult);
      end
      bus.ALUControl = 4'd15;
      #1;
      checks++;
      if (bus.ALUResult !== 32'hFFFFFFFA) begin
         errors++;
         $display("FAIL mflo_new: got %h, want fffffffa", bus.ALUResult);
      end
      // Registers hold while a non-MULT op sits across an edge
      @(posedge clk);
      #1;
      checks++;
      if (bus.ALUResult !== 32'hFFFFFFFA) begin
         errors++;
         $display("FAIL mflo_hold: got %h, want fffffffa", bus.ALUResult);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      bus.ALUControl = 4'd14;
      reset = 1'b1;
      #1;
      checks++;
      if (bus.ALUResult !== 32'h0 || bus.Zero !== 1'b1) begin
         errors++;
         $display("FAIL async_reset_hi: got %h zero=%b, want 00000000 zero=1", bus.ALUResult, bus.Zero);
      end
      bus.ALUControl = 4'd13;
      bus.A = 32'h5;
      bus.B = 32'h7;
      #1;
      checks++;
      if (bus.ALUResult !== 32'h23) begin
         errors++;
         $display("FAIL mult_comb_in_reset: got %h, want 00000023", bus.ALUResult);
      end
      @(posedge clk);
      #1;
      bus.ALUControl = 4'd15;
      #1;
      checks++;
      if (bus.ALUResult !== 32'h0) begin
         errors++;
         $display("FAIL mult_blocked_by_reset: got %h, want 00000000", bus.ALUResult);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (bus.ALUResult !== 32'h0) begin
         errors++;
         $display("FAIL lo_after_release: got %h, want 00000000", bus.ALUResult);
      end
      bus.ALUControl = 4'd13;
      @(posedge clk);
      #1;
      bus.ALUControl = 4'd15;
      #1;
      checks++;
      if (bus.ALUResult !== 32'h23) begin
         errors++;
         $display("FAIL mult_after_release: got %h, want 00000023", bus.ALUResult);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      bus.ALUControl = 4'd0;
      bus.A = 32'h0;
      bus.B = 32'h0;
      #2;
      test_reset();
      @(negedge clk);
      reset = 1'b0;
      test_branch_flags();
      test_arith_logic();
      test_shifts();
      test_mult();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_32bit.md
# alu_32bit

Combinational 32-bit integer ALU for the MIPS-style datapath, located in the EX stage. It computes `ALUResult` and `Zero` from operands `A` and `B` under a 4-bit `ALUControl` code. It also holds a clocked HI/LO product register pair that is written by the multiply operation and read back by the move-from operations. The branch-compare codes produce a 0/1 flag. The branch unit uses `Zero`, or its inverse, to resolve bltz/bgez/blez/bgtz.

## Interface
- No parameters.
- `Clk`  input  1  — rising-edge clock for the HI/LO registers only.
- `Reset`  input  1  — asynchronous, active-high; clears HI and LO.
- `ALUControl`  input  4  — operation select (encoding below).
- `A`  input  32  — operand A; shift amount taken from `A[4:0]`.
- `B`  input  32  — operand B; the value shifted for shift ops.
- `ALUResult`  output  32  — combinational result.
- `Zero`  output  1  — 1 when `ALUResult == 32'h0`, else 0.

## Operation
- `ALUResult`/`Zero` are purely combinational: any input change propagates with no clock.
- Encoding (arithmetic is two's complement, mod 2^32, no overflow trap; flag ops return 32'h1 or 32'h0):
  - 0 AND: `A & B`
  - 1 OR: `A | B`
  - 2 ADD: `A + B`
  - 3 XOR: `A ^ B`
  - 4 NOR: `~(A | B)`
  - 5 SLL: `B << A[4:0]`
  - 6 SUB: `A - B`
  - 7 LTZ: 1 if signed `A < 0` (bltz; bgez uses inverse)
  - 8 SLT: 1 if signed `A < B`
  - 9 LEZ: 1 if signed `A <= 0` (blez; bgtz uses inverse)
  - 10 SRL: `B >> A[4:0]`, zero fill
  - 11 SRA: `B >>> A[4:0]`, sign fill
  - 12 SLTU: 1 if unsigned `A < B`
  - 13 MULT: ALUResult = low 32 bits of signed `A*B`; HI/LO captures the full product at the next edge
  - 14 MFHI: ALUResult = HI
  - 15 MFLO: ALUResult = LO
- Codes 7 and 9 ignore `B`.
- The ALU never inverts `Zero`. Branch negation for bgez/bgtz is performed outside this block.
- HI/LO:
  - Two 32-bit registers, {HI,LO} = 64-bit signed product of `A` and `B`.
  - Written only on a rising `Clk` while `ALUControl == 13`; otherwise they hold their value.

## Timing
- `ALUResult`/`Zero`: combinational, zero-cycle latency; must settle within one clock period.
- HI/LO write: one-cycle latency. A MULT at edge N makes MFHI/MFLO return the new product from after edge N onward.
- Same-cycle MFHI/MFLO returns the pre-edge (old) value; no internal forwarding.
- Reset asserted (asynchronous): HI = LO = 0 immediately, regardless of `Clk`. While `Reset` is high, MULT does not write.
- Reset deasserted: normal capture resumes at the next rising edge.
- Reset does not affect combinational ops 0–13. During reset, MFHI/MFLO return 0 and `Zero` = 1.
- Shift amount ≥ 32 is impossible; only `A[4:0]` is used. `A[4:0] == 0` passes `B` through unchanged.

## Test plan
- LTZ (code 7), B=0: A=-5 → ALUResult=1, Zero=0; A=0 → 0, Zero=1; A=3 → 0, Zero=1.
- LEZ (code 9), B=0: A=-5 → 1, Zero=0; A=0 → 1, Zero=0; A=3 → 0, Zero=1.
- Arithmetic/logic:
  - ADD 32'h7FFFFFFF+1 → 32'h80000000.
  - SUB 5-5 → 0, Zero=1.
  - NOR 0,0 → 32'hFFFFFFFF.
  - SLT -1,1 → 1.
  - SLTU 32'hFFFFFFFF,1 → 0.
- Shifts with B=32'h80000001:
  - SLL A=4 → 32'h00000010.
  - SRL A=4 → 32'h08000000.
  - SRA A=4 → 32'hF8000000.
- MULT A=-2, B=3:
  - Combinational ALUResult = 32'hFFFFFFFA.
  - After one rising edge: MFHI → 32'hFFFFFFFF, MFLO → 32'hFFFFFFFA.
  - Same-cycle MFHI before that edge → old HI.
- Reset: load HI/LO via MULT, then assert `Reset` between edges → MFHI/MFLO read 0 immediately. A MULT presented during reset leaves HI/LO at 0.
